// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and bounds for the bit-serial adder sequencer.
// Optional feature macro (used by the top and interface): SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  // Sequencer state; encoding is fixed so waveforms read the same everywhere.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Legal operand width range.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand request and result response handshakes.
// SERIAL_ADDER_OVF_EN adds the signed-overflow result bit out_ovf.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             out_ovf;
`endif

  // Producer/consumer side (drives operands, takes results).
  modport master (
    output in_valid, in_a, in_b, in_carry, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_sum, out_carry, busy
  );

  // Adder side.
  modport slave (
    input  in_valid, in_a, in_b, in_carry, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_sum, out_carry, busy
  );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// ha_1b / fa_1b: the single adder cell walked over the operands bit by bit.

// Half adder.
module ha_1b (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// Full adder from two half adders; the two partial carries never both set.
module fa_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  ha_1b u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  ha_1b u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: area-minimal WIDTH-bit adder. Operands are captured on
// accept, then one full-adder cell is stepped LSB-first for WIDTH cycles; the
// sum is assembled by shifting into the MSB of a result register.
// Optional: SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of legal range");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             cry;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  // Accept is qualified by state only, so in_ready never depends on in_valid.
  assign accept   = (state == IDLE) & bus.in_valid;
  assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // The one and only adder cell.
  fa_1b u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (cry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs are pure state decodes.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      RUN:     bus.busy      = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Datapath: capture on accept, one bit per RUN cycle, hold otherwise.
  // The result register is not cleared on capture; its contents during RUN
  // are partial shifts and only meaningful once out_valid is up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      cry  <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= bus.in_a;
      b_sh <= bus.in_b;
      cry  <= bus.in_carry;
      cnt  <= '0;
    end else if (state == RUN) begin
      res  <= {fa_s, res[WIDTH-1:1]};
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cry  <= fa_co;
      cnt  <= cnt + 1'b1;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit, cry is the carry into the MSB and fa_co the carry out;
  // their disagreement is two's-complement overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf <= 1'b0;
    else if (last_bit) ovf <= cry ^ fa_co;
  end

  assign bus.out_ovf = ovf;
`endif

  assign bus.out_sum   = res;
  assign bus.out_carry = cry;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder sequencer. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then walks one shared 1-bit full-adder cell LSB-first over WIDTH cycles and presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits in the arithmetic_modules group as the area-minimal adder option, trading latency for a single adder cell.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- CLK  input  1  clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-high.
- IN_VALID  input  1  operand request.
- IN_READY  output  1  block can accept operands; high only in IDLE.
- IN_A  input  WIDTH  operand A.
- IN_B  input  WIDTH  operand B.
- IN_CARRY  input  1  carry-in.
- OUT_VALID  output  1  result available; high only in DONE.
- OUT_READY  input  1  consumer accepts result.
- OUT_SUM  output  WIDTH  sum, (IN_A + IN_B + IN_CARRY) mod 2^WIDTH.
- OUT_CARRY  output  1  carry-out of bit WIDTH-1.
- BUSY  output  1  high in RUN or DONE.
- OUT_OVF  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States are IDLE, RUN and DONE; reset state is IDLE.
- IDLE→RUN on IN_VALID & IN_READY at a rising edge:
  - capture IN_A and IN_B into shift registers;
  - capture IN_CARRY into the carry register;
  - clear the bit counter to 0.
- In each RUN cycle:
  - the full-adder cell takes shift-register LSBs a0 and b0 plus the carry register;
  - the sum bit shifts into the MSB of the result register, which shifts right;
  - A and B shift right;
  - the carry register takes the cell's carry-out;
  - the counter increments.
- RUN→DONE on the edge where the counter equals WIDTH-1. That edge performs the final bit's update.
- DONE→IDLE on OUT_VALID & OUT_READY.
- OUT_SUM and OUT_CARRY drive directly from the result and carry registers.
  - They are valid only while OUT_VALID is high.
  - They hold their values from DONE until the next capture.
  - They are undefined-but-deterministic during RUN, meaning partial shift contents.
- IN_VALID and operand changes during RUN or DONE are ignored. Operands are sampled only on the accept edge.
- There is no bypass. After a DONE pop, IN_READY rises in the following cycle.
- Reset values: IN_READY=1, OUT_VALID=0, BUSY=0, OUT_SUM=0, OUT_CARRY=0, OUT_OVF=0; all internal registers 0.
- Reset asserted mid-RUN or in DONE aborts the operation. No OUT_VALID is produced and the pending result is discarded.
- Arithmetic is unsigned. The carry chain runs through one cell only, with no parallel carry logic.

## Timing
- Let t0 be the accepting edge. OUT_VALID goes high in the cycle after edge t0+WIDTH, so latency is WIDTH cycles from accept.
- Minimum initiation interval is WIDTH+2 cycles: WIDTH RUN cycles, at least 1 DONE cycle, and 1 IDLE cycle.
- OUT_VALID, OUT_SUM and OUT_CARRY stay stable while OUT_READY is low. Backpressure is unbounded.
- IN_READY is a pure state decode with no combinational path from IN_VALID. OUT_VALID likewise has no path from OUT_READY.
- All outputs are registered or state-decoded.

## Configuration
- SERIAL_ADDER_OVF_EN, when defined:
  - adds an OUT_OVF port and a 1-bit register;
  - on the final RUN edge, OUT_OVF = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
  - OUT_OVF holds with OUT_SUM and resets to 0.
- SERIAL_ADDER_OVF_EN, when undefined: the port and register are absent and all other behaviour is identical.

## Structure
- Package serial_adder_pkg holds:
  - the state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the WIDTH legality bounds.
- The counter width is $clog2(WIDTH), computed locally.
- Sub-module fa_1b is a 1-bit full adder built from two ha_1b instances plus an OR of their carries. It is instantiated exactly once.

## Test plan
- WIDTH=8, A=0x0F, B=0x01, CIN=0 → SUM=0x10, CARRY=0; OUT_VALID exactly 8 cycles after accept.
- A=0xFF, B=0x01, CIN=0 → SUM=0x00, CARRY=1; with SERIAL_ADDER_OVF_EN, OUT_OVF=0.
- A=0x7F, B=0x00, CIN=1 → SUM=0x80, CARRY=0, OUT_OVF=1. Without the macro, the port is absent and SUM/CARRY are unchanged.
- OUT_READY held low 5 cycles in DONE → OUT_SUM, OUT_CARRY and OUT_VALID stable and IN_READY=0. Pop → IN_READY=1 in the next cycle; back-to-back accept succeeds.
- IN_VALID held high with IN_A changing every cycle during RUN → result reflects the operands captured at accept; no second accept until IDLE.
- RST pulsed after the 3rd RUN edge → all outputs at reset values; IN_READY=1 after deassert; no OUT_VALID for the aborted operation. A following 0x55+0xAA, CIN=1 yields SUM=0x00, CARRY=1.
